mult5_acc: RTL and testbench

Sequential accumulate stage directly downstream of the 5x5 combinational multiplier `mult_5`. It consumes the 10-bit product `z_9..z_0` one beat per handshake and sums a frame of `COUNT` products into an `ACC_W`-bit result. The result is offered on a valid/ready output with an overflow flag. The block adds the clocked, flow-controlled boundary the combinational multiplier lacks, turning it into a dot-product / MAC unit.

---
 rtl/mult5_acc_if.sv | 24 ++
 rtl/mult5_acc.sv | 108 ++++++++++
 tb/tb_mult5_acc.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mult5_acc_if.sv
// Product-in / frame-result-out bundle for mult5_acc.
// slave: the accumulator side; master: the upstream/downstream driver side.
interface mult5_acc_if #(
  parameter int ACC_W = 12
);
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [9:0]       prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  modport slave (
    input  clr, in_valid, prod, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

  modport master (
    output clr, in_valid, prod, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/mult5_acc.sv
// mult5_acc: sums COUNT unsigned 10-bit products from mult_5 into an
// ACC_W-bit frame result offered on a valid/ready output with an overflow flag.
// Optional feature: define MULT5_ACC_SAT_EN to saturate at 2^ACC_W-1 instead
// of wrapping modulo 2^ACC_W.
//
// state | meaning
// ------+----------------------------------------------------------
// ACC   | accepting beats (in_ready=1), summing the current frame
// HOLD  | frame result offered (out_valid=1), waiting for out_ready
module mult5_acc #(
  parameter int ACC_W = 12,
  parameter int COUNT = 8
) (
  input logic        clk,
  input logic        rst,
  mult5_acc_if.slave bus
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  typedef enum logic {ACC, HOLD} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             in_ready;
  logic             out_valid;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] next_acc;

  // One extra bit captures the carry out of the accumulator MSB.
  always_comb begin
    sum   = {1'b0, acc} + {{(ACC_W - 9){1'b0}}, bus.prod};
    carry = sum[ACC_W];
`ifdef MULT5_ACC_SAT_EN
    // Once saturated, acc is all ones, so any further add carries again and
    // the value stays pinned for the rest of the frame.
    next_acc = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    next_acc = sum[ACC_W-1:0];
`endif
  end

  // Frame FSM with registered handshake outputs and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (bus.clr) begin
            // A beat arriving with clr is consumed and discarded.
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end else if (bus.in_valid) begin
            if (cnt == LAST) begin
              out_data  <= next_acc;
              out_ovf   <= ovf | carry;
              acc       <= '0;
              cnt       <= '0;
              ovf       <= 1'b0;
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              acc <= next_acc;
              cnt <= cnt + CNT_W'(1);
              ovf <= ovf | carry;
            end
          end
        end
        HOLD: begin
          // clr is ignored here so a completed result is never lost.
          if (bus.out_ready) begin
            state     <= ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACC;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_ovf   = out_ovf;

endmodule

// File: tb/tb_mult5_acc.sv
// Bench for mult5_acc: table-driven frames, hand-written corner sequences and
// a randomized phase, all checked against a frame-sum scoreboard.
module tb_mult5_acc;

  localparam int ACC_W = 12;
  localparam int COUNT = 8;
  localparam int MAXV  = (1 << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mult5_acc_if #(.ACC_W(ACC_W)) bus ();

  mult5_acc #(.ACC_W(ACC_W), .COUNT(COUNT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: a frame result is the plain integer sum of its products,
  // reduced by wrap or saturation; overflow means the total exceeded MAXV.
  typedef struct { int data; bit ovf; } res_t;
  res_t    exp_q[$];
  longint  m_total = 0;
  int      m_n     = 0;

  function automatic res_t frame_result(input longint total);
    res_t r;
    r.ovf = (total > MAXV);
`ifdef MULT5_ACC_SAT_EN
    r.data = r.ovf ? MAXV : int'(total);
`else
    r.data = int'(total % (MAXV + 1));
`endif
    return r;
  endfunction

  // Scoreboard: observe settled signals mid-cycle, i.e. what the next rising
  // edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      m_total = 0;
      m_n     = 0;
      exp_q.delete();
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("stale_out_valid", 1, 0);
        end else begin
          chk("sb_out_data", bus.out_data, exp_q[0].data);
          chk("sb_out_ovf", bus.out_ovf, exp_q[0].ovf);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_ready) begin
        if (bus.clr) begin
          m_total = 0;
          m_n     = 0;
        end else if (bus.in_valid) begin
          m_total += bus.prod;
          m_n++;
          if (m_n == COUNT) begin
            exp_q.push_back(frame_result(m_total));
            m_total = 0;
            m_n     = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int v);
    bus.in_valid = 1'b1;
    bus.prod     = 10'(v);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic frame_1to8();
    for (int j = 1; j <= 8; j++) beat(j);
  endtask

  typedef struct {
    int p [8];
    int exp_data;
    bit exp_ovf;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{'{1, 2, 3, 4, 5, 6, 7, 8}, 36, 1'b0};
    vecs[1] = '{'{7, 7, 7, 7, 7, 7, 7, 7}, 56, 1'b0};
    vecs[2] = '{'{0, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b0};
    vecs[3] = '{'{100, 150, 200, 250, 300, 350, 400, 450}, 2200, 1'b0};
    vecs[4] = '{'{1023, 1023, 1023, 1023, 3, 0, 0, 0}, 4095, 1'b0};
`ifdef MULT5_ACC_SAT_EN
    vecs[5] = '{'{961, 961, 961, 961, 961, 961, 961, 961}, 4095, 1'b1};
    vecs[6] = '{'{1023, 1023, 1023, 1023, 4, 0, 0, 0}, 4095, 1'b1};
`else
    vecs[5] = '{'{961, 961, 961, 961, 961, 961, 961, 961}, 3592, 1'b1};
    vecs[6] = '{'{1023, 1023, 1023, 1023, 4, 0, 0, 0}, 0, 1'b1};
`endif

    bus.clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.prod      = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_ovf", bus.out_ovf, 0);
    rst = 1'b0;
    tick();

    // Table-driven frames, back-to-back beats, result taken immediately.
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 8; j++) beat(vecs[i].p[j]);
      chk("vec_out_valid", bus.out_valid, 1);
      chk("vec_in_ready_low", bus.in_ready, 0);
      chk("vec_out_data", bus.out_data, vecs[i].exp_data);
      chk("vec_out_ovf", bus.out_ovf, vecs[i].exp_ovf);
      tick();
      chk("vec_in_ready_back", bus.in_ready, 1);
      chk("vec_out_valid_drop", bus.out_valid, 0);
    end

    // Backpressure: upstream keeps offering 7 while the result is held.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      bus.prod = 10'(j);
      tick();
    end
    bus.prod = 10'd7;
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_data", bus.out_data, 36);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release", bus.out_valid, 0);
    repeat (7) tick();
    chk("bp_next_not_done", bus.out_valid, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_next_valid", bus.out_valid, 1);
    chk("bp_next_data", bus.out_data, 56);
    tick();

    // clr coincident with a beat drops that beat and the partial sum.
    repeat (3) beat(100);
    bus.clr = 1'b1;
    beat(100);
    bus.clr = 1'b0;
    repeat (8) beat(2);
    chk("clr_out_valid", bus.out_valid, 1);
    chk("clr_out_data", bus.out_data, 16);
    chk("clr_out_ovf", bus.out_ovf, 0);
    tick();

    // Reset mid-frame.
    repeat (5) beat(10);
    rst = 1'b1;
    #1;
    chk("rstmid_out_valid", bus.out_valid, 0);
    chk("rstmid_in_ready", bus.in_ready, 1);
    tick();
    rst = 1'b0;
    repeat (8) beat(3);
    chk("rstmid_valid", bus.out_valid, 1);
    chk("rstmid_data", bus.out_data, 24);
    tick();

    // Reset while a result is held: it is lost.
    bus.out_ready = 1'b0;
    frame_1to8();
    chk("rsthold_pre", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rsthold_valid", bus.out_valid, 0);
    chk("rsthold_data", bus.out_data, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rsthold_after", bus.out_valid, 0);

    // clr during HOLD is ignored.
    frame_1to8();
    bus.clr = 1'b1;
    repeat (2) tick();
    bus.clr = 1'b0;
    chk("clrhold_valid", bus.out_valid, 1);
    chk("clrhold_data", bus.out_data, 36);
    bus.out_ready = 1'b1;
    tick();
    chk("clrhold_done", bus.out_valid, 0);

    // Randomized traffic: 5x5 products, sparse clr, random backpressure.
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.prod      = 10'($urandom_range(31) * $urandom_range(31));
      bus.clr       = ($urandom_range(15) == 0);
      bus.out_ready = ($urandom_range(2) != 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.clr       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_idle_valid", bus.out_valid, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
